// File: rtl/usb_host_tx_phy.sv
// Full-speed USB host line transmitter: byte stream in, NRZI + bit-stuffed D+/D- out,
// each packet framed with SYNC and a 2-bit SE0 + 1-bit J end-of-packet.
module usb_host_tx_phy #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk48_host,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_d_p_o,
  output logic       usb_d_n_o,
  output logic       usb_oe,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PhaseMax = PW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_t;

  state_t        r_state, w_state;
  logic [PW-1:0] r_phase, w_phase;
  logic [2:0]    r_bitcnt, w_bitcnt;
  logic [7:0]    r_shift, w_shift;
  logic [2:0]    r_ones, w_ones;
  logic          r_last, w_last;
  logic          r_fin, w_fin;
  logic          r_stuff, w_stuff;
  logic          r_j, w_j;

  logic w_bit_end, w_req, w_emit, w_ebit, w_to_eop;

  assign w_bit_end = (r_phase == PhaseMax);
  // Byte-request cycle: last clock of data bit 7 of a byte that is not the final one.
  assign w_req = (r_state == StData) && w_bit_end && !r_stuff && (r_bitcnt == 3'd7) && !r_last;

  assign tx_ready  = !reset && ((r_state == StIdle) || w_req);
  assign underrun  = w_req && !tx_valid;
  assign busy      = (r_state != StIdle);
  assign usb_oe    = busy;
  assign usb_d_p_o = (r_state != StEopSe0) && r_j;
  assign usb_d_n_o = (r_state != StEopSe0) && !r_j;

  always_comb begin
    w_state  = r_state;
    w_phase  = w_bit_end ? '0 : r_phase + PW'(1);
    w_bitcnt = r_bitcnt;
    w_shift  = r_shift;
    w_ones   = r_ones;
    w_last   = r_last;
    w_fin    = r_fin;
    w_stuff  = r_stuff;
    w_j      = r_j;
    w_emit   = 1'b0;
    w_ebit   = 1'b0;
    w_to_eop = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_phase = '0;
        if (tx_valid) begin
          w_state  = StSync;
          w_shift  = tx_data;
          w_last   = tx_last;
          w_fin    = 1'b0;
          w_stuff  = 1'b0;
          w_bitcnt = '0;
          w_emit   = 1'b1;
        end
      end
      StSync: begin
        if (w_bit_end) begin
          w_emit = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state  = StData;
            w_bitcnt = '0;
            w_ebit   = r_shift[0];
          end else begin
            w_bitcnt = r_bitcnt + 3'd1;
            w_ebit   = (r_bitcnt == 3'd6);
          end
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_stuff) begin
            w_stuff = 1'b0;
            if (r_fin) begin
              w_to_eop = 1'b1;
            end else begin
              w_emit = 1'b1;
              w_ebit = r_shift[0];
            end
          end else begin
            if (r_bitcnt != 3'd7) begin
              w_shift  = r_shift >> 1;
              w_bitcnt = r_bitcnt + 3'd1;
              w_emit   = 1'b1;
              w_ebit   = r_shift[1];
            end else if (!r_last && tx_valid) begin
              w_shift  = tx_data;
              w_last   = tx_last;
              w_bitcnt = '0;
              w_emit   = 1'b1;
              w_ebit   = tx_data[0];
            end else if (r_ones == 3'd6) begin
              w_fin = 1'b1;
            end else begin
              w_to_eop = 1'b1;
            end
            // Six ones in a row: the next period is a stuffed 0, the data bit waits.
            if (r_ones == 3'd6) begin
              w_emit  = 1'b1;
              w_ebit  = 1'b0;
              w_stuff = 1'b1;
            end
          end
        end
      end
      StEopSe0: begin
        if (w_bit_end) begin
          if (r_bitcnt == 3'd1) begin
            w_state = StEopJ;
            w_j     = 1'b1;
          end else begin
            w_bitcnt = r_bitcnt + 3'd1;
          end
        end
      end
      StEopJ: begin
        if (w_bit_end) begin
          w_state = StIdle;
          w_j     = 1'b1;
        end
      end
      default: w_state = StIdle;
    endcase

    if (w_to_eop) begin
      w_state  = StEopSe0;
      w_bitcnt = '0;
    end

    if (w_emit) begin
      if (w_ebit) begin
        w_ones = r_ones + 3'd1;
      end else begin
        w_j    = !r_j;
        w_ones = '0;
      end
    end
  end

  always_ff @(posedge clk48_host or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_phase  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ones   <= '0;
      r_last   <= 1'b0;
      r_fin    <= 1'b0;
      r_stuff  <= 1'b0;
      r_j      <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_phase  <= w_phase;
      r_bitcnt <= w_bitcnt;
      r_shift  <= w_shift;
      r_ones   <= w_ones;
      r_last   <= w_last;
      r_fin    <= w_fin;
      r_stuff  <= w_stuff;
      r_j      <= w_j;
    end
  end

endmodule
